// File: rtl/vdp2_cram_lookup_if.sv
// vdp2_cram_lookup_if: dot handshake, CRAM port B and RGB output bundle for the CRAM lookup stage
interface vdp2_cram_lookup_if;
  logic              DOT_VALID;
  logic              DOT_READY;
  logic [10:0]       DOT_INDEX;
  logic              DOT_TRANSP;
  logic [1:0]        CRMD;
  logic [10:0]       CRAM_ADDR;
  logic [15:0]       CRAM_Q;
  logic signed [8:0] COF_R;
  logic signed [8:0] COF_G;
  logic signed [8:0] COF_B;
  logic              COF_ENA;
  logic              RGB_VALID;
  logic [7:0]        RGB_R;
  logic [7:0]        RGB_G;
  logic [7:0]        RGB_B;
  logic              RGB_MSB;
  logic              RGB_TRANSP;
  modport master (
    output DOT_VALID, DOT_INDEX, DOT_TRANSP, CRMD, CRAM_Q, COF_R, COF_G, COF_B, COF_ENA,
    input  DOT_READY, CRAM_ADDR, RGB_VALID, RGB_R, RGB_G, RGB_B, RGB_MSB, RGB_TRANSP
  );
  modport slave (
    input  DOT_VALID, DOT_INDEX, DOT_TRANSP, CRMD, CRAM_Q, COF_R, COF_G, COF_B, COF_ENA,
    output DOT_READY, CRAM_ADDR, RGB_VALID, RGB_R, RGB_G, RGB_B, RGB_MSB, RGB_TRANSP
  );
endinterface

// File: rtl/vdp2_cram_lookup.sv
// vdp2_cram_lookup: palette index -> CRAM port B read -> 8-bit RGB with MSB/transparent flags
// Define VDP2_CRAM_COFS_EN to add the saturating per-channel colour offset in the output stage.
module vdp2_cram_lookup (
  input logic CLK,
  input logic RST,
  input logic CE,
  vdp2_cram_lookup_if.slave bus
);
  typedef enum logic {IDLE, HI2} state_t;
  state_t state, state_nx;
  logic acc, m2_acc;
  logic [10:0] addr_nx;
  logic p1_v, p1_m2, p1_tr, p2_v, p2_m2, p2_tr, p3_v;
  logic [7:0] lo_b;
  logic lo_msb;
  logic out_v, out_tr, out_msb;
  logic [7:0] raw_r, raw_g, raw_b, out_r, out_g, out_b;
  function automatic logic [7:0] ex5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction
  assign acc = CE & bus.DOT_VALID & bus.DOT_READY;
  assign m2_acc = acc & ~bus.DOT_TRANSP & (bus.CRMD == 2'd2);
  assign addr_nx = bus.CRMD == 2'd0 ? {1'b0, bus.DOT_INDEX[9:0]} :
                   bus.CRMD == 2'd2 ? {bus.DOT_INDEX[9:0], 1'b0} : bus.DOT_INDEX;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else if (CE) state <= state_nx;
  always_comb state_nx = (state == IDLE && m2_acc) ? HI2 : IDLE;
  always_comb bus.DOT_READY = state == IDLE;
  // p2 is the stage whose CRAM word is on CRAM_Q; p3 holds a mode-2 dot waiting for its odd word
  always_comb begin
    out_v   = (p2_v & ~p2_m2) | p3_v;
    out_tr  = ~p3_v & p2_tr;
    out_msb = p3_v ? lo_msb : ~p2_tr & bus.CRAM_Q[15];
    raw_r   = p3_v ? bus.CRAM_Q[7:0]  : p2_tr ? 8'd0 : ex5(bus.CRAM_Q[4:0]);
    raw_g   = p3_v ? bus.CRAM_Q[15:8] : p2_tr ? 8'd0 : ex5(bus.CRAM_Q[9:5]);
    raw_b   = p3_v ? lo_b             : p2_tr ? 8'd0 : ex5(bus.CRAM_Q[14:10]);
  end
`ifdef VDP2_CRAM_COFS_EN
  function automatic logic [7:0] sat(input logic [7:0] c, input logic signed [8:0] o);
    logic signed [9:0] s;
    s = $signed({2'b00, c}) + $signed({o[8], o});
    return s[9] ? 8'd0 : s[8] ? 8'd255 : s[7:0];
  endfunction
  logic cof_on;
  assign cof_on = bus.COF_ENA & ~out_tr;
  assign out_r = cof_on ? sat(raw_r, bus.COF_R) : raw_r;
  assign out_g = cof_on ? sat(raw_g, bus.COF_G) : raw_g;
  assign out_b = cof_on ? sat(raw_b, bus.COF_B) : raw_b;
`else
  assign out_r = raw_r;
  assign out_g = raw_g;
  assign out_b = raw_b;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      bus.CRAM_ADDR  <= '0;
      {p1_v, p1_m2, p1_tr, p2_v, p2_m2, p2_tr, p3_v} <= '0;
      lo_b           <= '0;
      lo_msb         <= 1'b0;
      bus.RGB_VALID  <= 1'b0;
      bus.RGB_R      <= '0;
      bus.RGB_G      <= '0;
      bus.RGB_B      <= '0;
      bus.RGB_MSB    <= 1'b0;
      bus.RGB_TRANSP <= 1'b0;
    end else if (CE) begin
      {p1_v, p1_m2, p1_tr} <= {acc, m2_acc, bus.DOT_TRANSP};
      {p2_v, p2_m2, p2_tr} <= {p1_v, p1_m2, p1_tr};
      p3_v <= p2_v & p2_m2;
      if (state == HI2) bus.CRAM_ADDR <= bus.CRAM_ADDR + 11'd1;
      else if (acc & ~bus.DOT_TRANSP) bus.CRAM_ADDR <= addr_nx;
      if (p2_v & p2_m2) begin
        lo_b   <= bus.CRAM_Q[7:0];
        lo_msb <= bus.CRAM_Q[15];
      end
      bus.RGB_VALID <= out_v;
      if (out_v) begin
        bus.RGB_R      <= out_r;
        bus.RGB_G      <= out_g;
        bus.RGB_B      <= out_b;
        bus.RGB_MSB    <= out_msb;
        bus.RGB_TRANSP <= out_tr;
      end
    end
endmodule

// File: tb/tb_vdp2_cram_lookup.sv
// tb_vdp2_cram_lookup: random and directed dots against a queue-based colour model and a CRAM array
module tb_vdp2_cram_lookup;
  logic CLK = 1'b0;
  logic RST;
  logic CE;
  vdp2_cram_lookup_if bus();
  vdp2_cram_lookup dut (.CLK(CLK), .RST(RST), .CE(CE), .bus(bus));
  always #5 CLK = ~CLK;
  logic [15:0] mem [2048];
  logic [10:0] ram_a;
  // CRAM port B address register runs on the dot clock enable
  always @(posedge CLK) if (CE) ram_a <= bus.CRAM_ADDR;
  assign bus.CRAM_Q = mem[ram_a];
  typedef struct {
    int due;
    logic [7:0] r, g, b;
    logic msb, tr;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0, ce_cnt = 0;
  logic [10:0] e_addr;
  bit e_ready, e_valid, e_msb, e_tr, hi2, accepted;
  logic [7:0] e_r, e_g, e_b;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int exp5(input int c);
    return c * 8 + c / 4;
  endfunction
  function automatic logic [10:0] addr_of(input logic [10:0] idx, input logic [1:0] md);
    int a;
    a = md == 0 ? idx % 1024 : md == 2 ? (idx % 1024) * 2 : int'(idx);
    return 11'(a);
  endfunction
  function automatic exp_t colour(input logic [10:0] idx, input bit tr, input logic [1:0] md);
    exp_t e;
    logic [15:0] w0, w1;
    e = '{0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    if (tr) e.tr = 1'b1;
    else if (md == 2) begin
      w0 = mem[(idx % 1024) * 2];
      w1 = mem[(idx % 1024) * 2 + 1];
      e.r = w1[7:0]; e.g = w1[15:8]; e.b = w0[7:0]; e.msb = w0[15];
    end else begin
      w0 = mem[addr_of(idx, md)];
      e.r = 8'(exp5(int'(w0[4:0])));
      e.g = 8'(exp5(int'(w0[9:5])));
      e.b = 8'(exp5(int'(w0[14:10])));
      e.msb = w0[15];
    end
    return e;
  endfunction
`ifdef VDP2_CRAM_COFS_EN
  function automatic logic [7:0] sat(input logic [7:0] c, input logic signed [8:0] o);
    int v;
    v = int'(c) + int'(o);
    return v < 0 ? 8'd0 : v > 255 ? 8'd255 : 8'(v);
  endfunction
`endif
  task automatic step(input bit ce, input bit v, input logic [10:0] idx, input bit tr, input logic [1:0] md);
    bit acc;
    exp_t e;
    CE = ce; bus.DOT_VALID = v; bus.DOT_INDEX = idx; bus.DOT_TRANSP = tr; bus.CRMD = md;
`ifdef VDP2_CRAM_COFS_EN
    bus.COF_R = 9'($urandom); bus.COF_G = 9'($urandom); bus.COF_B = 9'($urandom);
    bus.COF_ENA = 1'($urandom);
`endif
    acc = ce && v && e_ready;
    accepted = acc;
    @(posedge CLK); #1;
    if (ce) begin
      ce_cnt++;
      if (hi2) e_addr = e_addr + 11'd1;
      else if (acc && !tr) e_addr = addr_of(idx, md);
      hi2 = acc && !tr && md == 2;
      e_ready = !hi2;
      if (acc) begin
        e = colour(idx, tr, md);
        e.due = ce_cnt + (hi2 ? 3 : 2);
        q.push_back(e);
      end
      e_valid = q.size() > 0 && q[0].due == ce_cnt;
      if (e_valid) begin
        e = q.pop_front();
`ifdef VDP2_CRAM_COFS_EN
        if (bus.COF_ENA && !e.tr) begin
          e.r = sat(e.r, bus.COF_R); e.g = sat(e.g, bus.COF_G); e.b = sat(e.b, bus.COF_B);
        end
`endif
        {e_r, e_g, e_b, e_msb, e_tr} = {e.r, e.g, e.b, e.msb, e.tr};
      end
    end
    check("ready", 32'(bus.DOT_READY), 32'(e_ready));
    check("addr", 32'(bus.CRAM_ADDR), 32'(e_addr));
    check("valid", 32'(bus.RGB_VALID), 32'(e_valid));
    check("rgb", {8'd0, bus.RGB_R, bus.RGB_G, bus.RGB_B}, {8'd0, e_r, e_g, e_b});
    check("msb", 32'(bus.RGB_MSB), 32'(e_msb));
    check("transp", 32'(bus.RGB_TRANSP), 32'(e_tr));
  endtask
  task automatic send(input logic [10:0] idx, input bit tr, input logic [1:0] md, input int gap);
    do begin
      repeat (gap) step(1'b0, 1'b1, idx, tr, md);
      step(1'b1, 1'b1, idx, tr, md);
    end while (!accepted);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 11'd0, 1'b0, 2'd0);
  endtask
  task automatic model_reset();
    q.delete();
    hi2 = 1'b0; e_ready = 1'b1; e_addr = '0; e_valid = 1'b0;
    {e_r, e_g, e_b, e_msb, e_tr} = '0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(bus.DOT_READY), 32'd1);
    check({tag, "_addr"}, 32'(bus.CRAM_ADDR), 32'd0);
    check({tag, "_valid"}, 32'(bus.RGB_VALID), 32'd0);
    check({tag, "_out"}, {22'd0, bus.RGB_R, bus.RGB_MSB, bus.RGB_TRANSP}, 32'd0);
    check({tag, "_gb"}, {16'd0, bus.RGB_G, bus.RGB_B}, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    RST = 1'b1; CE = 1'b0;
    bus.DOT_VALID = 1'b0; bus.DOT_INDEX = '0; bus.DOT_TRANSP = 1'b0; bus.CRMD = '0;
    bus.COF_R = '0; bus.COF_G = '0; bus.COF_B = '0; bus.COF_ENA = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("rst");
    RST = 1'b0;
    mem[11'h7FF] = 16'hFFFF;
    send(11'h7FF, 1'b0, 2'd1, 0);
    idle(3);
    mem[11'h0A5] = 16'h001F;
    send(11'h4A5, 1'b0, 2'd0, 0);
    idle(3);
    mem[11'h246] = 16'h8012;
    mem[11'h247] = 16'h3456;
    send(11'h123, 1'b0, 2'd2, 0);
    idle(4);
    send(11'h010, 1'b0, 2'd1, 1);
    send(11'h123, 1'b0, 2'd2, 1);
    send(11'h7FF, 1'b0, 2'd3, 1);
    send(11'h055, 1'b1, 2'd1, 1);
    repeat (6) begin
      step(1'b0, 1'b0, 11'd0, 1'b0, 2'd0);
      idle(1);
    end
    repeat (3000)
      step($urandom % 4 != 0, $urandom % 4 != 0, 11'($urandom), $urandom % 5 == 0, 2'($urandom));
    idle(6);
    send(11'h0FF, 1'b0, 2'd2, 0);
    RST = 1'b1;
    #2;
    check_reset_state("rst_hi2");
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(5);
    send(11'h001, 1'b0, 2'd1, 0);
    idle(4);
    check("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
